// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Controller for an NxN output-stationary systolic multiplier. It holds the
// A and B operand buffers and feeds skewed rows of A into the left edge and
// skewed columns of B into the top edge of the array. It also drives the
// array's clear, accumulate and shift enables, and captures the array
// accumulators into a result register that is handed off with a valid/ready
// handshake.
//
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to add the perf_runs and
// perf_stall counters (saturating, cleared on rst).
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel     operand write strobe, 0 = A buffer, 1 = B buffer
//   wr_addr/wr_data  row-major element index r*N+c and element value
//   start            begin a multiply (taken in IDLE only)
//   busy             high in CLEAR, STREAM and DRAIN
//   in_left_flat     N lanes of A elements, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_top_flat      N lanes of B elements, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   acc_rst          array accumulator clear (CLEAR state)
//   acc_en           array accumulate enable (STREAM state)
//   shift_en_right   array horizontal operand shift enable (STREAM state)
//   shift_en_down    array vertical operand shift enable (STREAM state)
//   acc_out_flat     array accumulators, element (i,j) at (i*N+j)*ACC_WIDTH
//   res_valid        result valid, high exactly while in DONE
//   res_data         captured result, same layout as acc_out_flat
//   res_ready        result consumer ready
//   perf_runs        (PERF_EN) completed DONE->IDLE handshakes
//   perf_stall       (PERF_EN) DONE cycles with res_ready low
// -----------------------------------------------------------------------------
module systolic_ctrl #(
   parameter int MATRIX_SIZE = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             wr_en,
   input  logic                                             wr_sel,
   input  logic [$clog2(MATRIX_SIZE*MATRIX_SIZE)-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]                            wr_data,
   input  logic                                             start,
   output logic                                             busy,
   output logic [DATA_WIDTH*MATRIX_SIZE-1:0]                in_left_flat,
   output logic [DATA_WIDTH*MATRIX_SIZE-1:0]                in_top_flat,
   output logic                                             acc_rst,
   output logic                                             acc_en,
   output logic                                             shift_en_right,
   output logic                                             shift_en_down,
   input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]     acc_out_flat,
   output logic                                             res_valid,
   output logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]     res_data,
   input  logic                                             res_ready
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [31:0]                                      perf_runs,
   output logic [31:0]                                      perf_stall
`endif
);

   localparam int N          = MATRIX_SIZE;
   localparam int NN         = N * N;
   localparam int AW         = $clog2(NN);
   localparam int STREAM_LEN = 3 * N - 2;
   localparam int CW         = $clog2(3 * N - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] a_mem_q [NN];
   logic [DATA_WIDTH-1:0] b_mem_q [NN];
   logic [ACC_WIDTH*NN-1:0] res_data_q;
   logic                  streaming;
   logic                  wr_ok;

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR:  state_d = S_STREAM;
         S_STREAM: begin
            if (cnt_q == CW'(STREAM_LEN - 1)) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN:  state_d = S_DONE;
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign streaming      = (state_q == S_STREAM);
   assign busy           = (state_q == S_CLEAR) || streaming || (state_q == S_DRAIN);
   assign acc_rst        = (state_q == S_CLEAR);
   assign acc_en         = streaming;
   assign shift_en_right = streaming;
   assign shift_en_down  = streaming;
   assign res_valid      = (state_q == S_DONE);

   // ---------------- operand buffers ----------------
   // Writes are accepted in IDLE and DONE only, so the matrices being streamed
   // never change underneath a run. A write coinciding with start lands on the
   // same edge, two cycles before the first STREAM cycle reads the buffer.
   assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < (AW + 1)'(NN));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NN; i++) begin
            a_mem_q[i] <= '0;
            b_mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         if (wr_sel) begin
            b_mem_q[wr_addr] <= wr_data;
         end else begin
            a_mem_q[wr_addr] <= wr_data;
         end
      end
   end

   // ---------------- skewed lane drive ----------------
   // Lane g is delayed by g cycles: on stream cycle t it carries operand
   // element k = t - g, or zero outside 0 <= k < N. The one-bit-wider k
   // keeps the t < g underflow detectable.
   genvar gi;
   generate
      for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
         logic [CW:0]   k_lane;
         logic          live;
         logic [AW-1:0] a_idx;
         logic [AW-1:0] b_idx;

         assign k_lane = {1'b0, cnt_q} - (CW + 1)'(gi);
         assign live   = streaming && ({1'b0, cnt_q} >= (CW + 1)'(gi))
                         && (k_lane < (CW + 1)'(N));
         assign a_idx  = AW'(gi * N) + AW'(k_lane);
         assign b_idx  = AW'(k_lane) * AW'(N) + AW'(gi);

         assign in_left_flat[gi*DATA_WIDTH +: DATA_WIDTH] = live ? a_mem_q[a_idx] : '0;
         assign in_top_flat[gi*DATA_WIDTH +: DATA_WIDTH]  = live ? b_mem_q[b_idx] : '0;
      end
   endgenerate

   // ---------------- result capture ----------------
   // DRAIN is the first cycle the accumulators include the last product.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data_q <= '0;
      end else if (state_q == S_DRAIN) begin
         res_data_q <= acc_out_flat;
      end
   end

   assign res_data = res_data_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] perf_runs_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_runs_q  <= '0;
         perf_stall_q <= '0;
      end else if (state_q == S_DONE) begin
         if (res_ready) begin
            if (perf_runs_q != '1) perf_runs_q <= perf_runs_q + 1'b1;
         end else begin
            if (perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
         end
      end
   end

   assign perf_runs  = perf_runs_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Bench for systolic_ctrl with N=3. A small output-stationary PE array stands
// in for the real array and feeds acc_out_flat. A reference model tracks the
// run timeline (cycles since start) and the operand buffers, and computes the
// expected result by plain matrix multiplication. Every cycle the DUT outputs
// are compared to that model; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

   localparam int N   = 3;
   localparam int DW  = 8;
   localparam int ACW = 32;
   localparam int NN  = N * N;
   localparam int AW  = 4;
   localparam int RW  = ACW * NN;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          res_ready = 1'b0;
   logic          busy, acc_rst, acc_en, shift_en_right, shift_en_down, res_valid;
   logic [DW*N-1:0] in_left_flat, in_top_flat;
   logic [RW-1:0] acc_out_flat, res_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0]   perf_runs, perf_stall;
`endif

   systolic_ctrl #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACW)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy),
      .in_left_flat(in_left_flat), .in_top_flat(in_top_flat),
      .acc_rst(acc_rst), .acc_en(acc_en),
      .shift_en_right(shift_en_right), .shift_en_down(shift_en_down),
      .acc_out_flat(acc_out_flat),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
`ifdef SYSTOLIC_CTRL_PERF_EN
      , .perf_runs(perf_runs), .perf_stall(perf_stall)
`endif
   );

   // ---------------- PE array stand-in ----------------
   logic [ACW-1:0] pe_acc [N][N];
   logic [DW-1:0]  pe_a   [N][N];
   logic [DW-1:0]  pe_b   [N][N];

   function automatic logic [DW-1:0] a_in(input int i, input int j);
      if (j == 0) return in_left_flat[i*DW +: DW];
      return pe_a[i][j-1];
   endfunction

   function automatic logic [DW-1:0] b_in(input int i, input int j);
      if (i == 0) return in_top_flat[j*DW +: DW];
      return pe_b[i-1][j];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (rst || acc_rst) begin
               pe_acc[i][j] <= '0;
               pe_a[i][j]   <= '0;
               pe_b[i][j]   <= '0;
            end else begin
               if (acc_en) pe_acc[i][j] <= pe_acc[i][j] + ACW'(a_in(i, j)) * ACW'(b_in(i, j));
               if (shift_en_right) pe_a[i][j] <= a_in(i, j);
               if (shift_en_down)  pe_b[i][j] <= b_in(i, j);
            end
         end
      end
   end

   always_comb begin
      acc_out_flat = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            acc_out_flat[(i*N+j)*ACW +: ACW] = pe_acc[i][j];
   end

   // ---------------- reference model ----------------
   // m_k: -1 when idle, otherwise cycles elapsed since start was taken
   // (1 = clear, 2..3N-1 = stream, 3N = drain, 3N+1 = result held).
   int            m_k = -1;
   logic [DW-1:0] m_a [NN];
   logic [DW-1:0] m_b [NN];
   logic [RW-1:0] m_res = '0;
   int            m_runs = 0;
   int            m_stall = 0;

   function automatic logic [RW-1:0] matmul();
      logic [RW-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += int'(m_a[i*N+k]) * int'(m_b[k*N+j]);
            r[(i*N+j)*ACW +: ACW] = ACW'(s);
         end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_k <= -1;
         for (int i = 0; i < NN; i++) begin
            m_a[i] <= '0;
            m_b[i] <= '0;
         end
         m_res   <= '0;
         m_runs  <= 0;
         m_stall <= 0;
      end else begin
         if (wr_en && !(m_k >= 1 && m_k <= 3*N) && int'(wr_addr) < NN) begin
            if (wr_sel) m_b[wr_addr] <= wr_data;
            else        m_a[wr_addr] <= wr_data;
         end
         if (m_k < 0) begin
            if (start) m_k <= 1;
         end else if (m_k >= 3*N + 1) begin
            if (res_ready) begin
               m_k    <= -1;
               m_runs <= m_runs + 1;
            end else begin
               m_stall <= m_stall + 1;
            end
         end else begin
            if (m_k == 3*N) m_res <= matmul();
            m_k <= m_k + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int n_err = 0;
   int n_checks = 0;
   int n_clr = 0;
   int n_en = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cycle_check();
      logic e_busy, e_clr, e_en, e_val;
      logic [DW*N-1:0] e_left, e_top;
      int t;
      e_busy = (m_k >= 1) && (m_k <= 3*N);
      e_clr  = (m_k == 1);
      e_en   = (m_k >= 2) && (m_k <= 3*N - 1);
      e_val  = (m_k >= 3*N + 1);
      e_left = '0;
      e_top  = '0;
      t = m_k - 2;
      if (e_en) begin
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
               e_left[i*DW +: DW] = m_a[i*N + t - i];
               e_top[i*DW +: DW]  = m_b[(t - i)*N + i];
            end
         end
      end
      chk("cyc_busy", busy, e_busy);
      chk("cyc_acc_rst", acc_rst, e_clr);
      chk("cyc_acc_en", acc_en, e_en);
      chk("cyc_shift_right", shift_en_right, e_en);
      chk("cyc_shift_down", shift_en_down, e_en);
      chk("cyc_res_valid", res_valid, e_val);
      chk("cyc_in_left", in_left_flat, e_left);
      chk("cyc_in_top", in_top_flat, e_top);
      chk("cyc_res_data", res_data, m_res);
      if (acc_rst) n_clr++;
      if (acc_en)  n_en++;
   endtask

   // One clock: compare on the falling edge, then move inputs 2ns after rise.
   task automatic tick();
      @(negedge clk);
      if (chk_on) cycle_check();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(addr);
      wr_data = DW'(data);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 1;
      while (!res_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(lat);
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   function automatic logic [RW-1:0] pack9(input int v [NN]);
      logic [RW-1:0] r;
      for (int i = 0; i < NN; i++) r[i*ACW +: ACW] = ACW'(v[i]);
      return r;
   endfunction

   initial begin
      int lat, c_clr, c_en;
      int ea [NN];
      int eb [NN];
      int er [NN];
      logic [RW-1:0] exp_aa;

      // ---- reset state ----
      rst = 1'b1;
      tick();
      chk_on = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_acc_en", acc_en, 0);
      chk("rst_res_data", res_data, 0);
      rst = 1'b0;
      tick();

      // ---- identity x [1..9], last write together with start ----
      for (int i = 0; i < NN; i++) wr(1'b0, i, (i % 4 == 0) ? 1 : 0);
      for (int i = 0; i < NN - 1; i++) wr(1'b1, i, i + 1);
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = AW'(8); wr_data = 8'd9; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      wait_valid(lat);
      chk("ident_latency", lat, 10);
      er = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      chk("ident_result", res_data, pack9(er));
      handshake();
      chk("ident_back_idle", busy | res_valid, 0);

      // ---- all 255 ----
      for (int i = 0; i < NN; i++) begin
         wr(1'b0, i, 255);
         wr(1'b1, i, 255);
      end
      c_clr = n_clr;
      c_en  = n_en;
      run(lat);
      chk("max_latency", lat, 10);
      for (int i = 0; i < NN; i++) er[i] = 195075;
      chk("max_result", res_data, pack9(er));
      chk("max_acc_rst_cycles", n_clr - c_clr, 1);
      chk("max_enable_cycles", n_en - c_en, 7);
      handshake();

      // ---- lane skew at t=2, then reset on stream cycle 3 ----
      for (int i = 0; i < NN; i++) begin
         ea[i] = i + 1;
         eb[i] = 10 * (i + 1);
         wr(1'b0, i, ea[i]);
         wr(1'b1, i, eb[i]);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("skew_left_t2", in_left_flat, {8'd7, 8'd5, 8'd3});
      chk("skew_top_t2", in_top_flat, {8'd30, 8'd50, 8'd70});
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_enables", {acc_rst, acc_en, shift_en_right, shift_en_down}, 0);
      chk("midrst_buses", {in_left_flat, in_top_flat}, 0);
      chk("midrst_res_data", res_data, 0);
      chk("midrst_res_valid", res_valid, 0);

      // reload and run to completion, stalling 20 cycles in DONE
      for (int i = 0; i < NN; i++) begin
         wr(1'b0, i, ea[i]);
         wr(1'b1, i, eb[i]);
      end
      run(lat);
      chk("reload_latency", lat, 10);
      er = '{300, 360, 420, 660, 810, 960, 1020, 1260, 1500};
      exp_aa = pack9(er);
      chk("reload_result", res_data, exp_aa);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("stall_valid", res_valid, 1);
         chk("stall_data", res_data, exp_aa);
      end
      handshake();
`ifdef SYSTOLIC_CTRL_PERF_EN
      chk("perf_runs", perf_runs, 1);
      chk("perf_stall", perf_stall, 20);
      chk("perf_runs_model", perf_runs, m_runs);
      chk("perf_stall_model", perf_stall, m_stall);
`endif

      // ---- writes and start pulses while busy ----
      start = 1'b1;
      tick();
      lat = 1;
      while (!res_valid && lat < 40) begin
         wr_en   = 1'b1;
         wr_sel  = lat[0];
         wr_addr = AW'(lat % NN);
         wr_data = 8'hEE;
         start   = lat[0];
         tick();
         lat++;
      end
      wr_en = 1'b0;
      chk("busywr_latency", lat, 10);
      chk("busywr_result", res_data, exp_aa);
      // start together with res_ready in DONE must return to IDLE
      start = 1'b1;
      res_ready = 1'b1;
      tick();
      start = 1'b0;
      res_ready = 1'b0;
      chk("done_start_ignored", busy | res_valid, 0);
      tick();
      chk("done_start_still_idle", busy, 0);

      // out-of-range addresses are ignored; rerun gives the same result
      wr(1'b0, 12, 255);
      wr(1'b1, 15, 255);
      run(lat);
      chk("rerun_latency", lat, 10);
      chk("rerun_result", res_data, exp_aa);
      handshake();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
